pwm11_meas: RTL and testbench
=============================

# pwm11_meas

Receive-side counterpart of the 11-bit PWM generator (`PWM11`). It samples a PWM waveform with a fixed 2^W-cycle period and recovers the W-bit duty value, one measurement per period. It also flags malformed waveforms: wrong period, or stuck high. It sits on the input path, either as a loopback checker for PWM11 or as the decoder for an externally produced PWM stream on the same clock.

## Interface
- W, 11: duty width. The PWM period is PERIOD = 2^W clocks.
- SYNC, 2: number of input synchronizer flops (0–3). Use 0 only when PWM_sig is generated on clk.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- PWM_sig  input  1  PWM waveform under measurement.
- duty  output  W  last recovered duty (high-cycle count per period).
- vld  output  1  one-cycle pulse; duty was just updated.
- err  output  1  one-cycle pulse; period or stuck-high violation detected.
- locked  output  1  high after the first good measurement; cleared by err or rst.

## Operation
- s: PWM_sig after SYNC flops. s_d: s delayed one clock. rise = s & ~s_d.
- Counters, all W+1 bits and saturating at PERIOD:
  - per_cnt: cycles since the last rise.
  - hi_cnt: high cycles since the last rise.
  - lo_run: consecutive low cycles.
  - hi_run: consecutive high cycles.
- States: IDLE, MEAS.
- IDLE (entered on reset and after any err):
  - On rise: per_cnt=1, hi_cnt=1, go to MEAS. No publish.
  - Low-run timeout works the same as in MEAS.
- MEAS:
  - Each cycle: per_cnt+1, and hi_cnt+1 if s=1.
  - On rise with per_cnt==PERIOD: duty<=hi_cnt[W-1:0], vld pulse, locked<=1. Reload per_cnt=1, hi_cnt=1.
  - On rise with per_cnt!=PERIOD: err pulse, locked<=0, no vld. Reload the counters and stay in MEAS; this rise starts a new candidate period.
- Low timeout (any state): when lo_run reaches PERIOD:
  - duty<=0, vld pulse, locked<=1, lo_run reloads to 0. This repeats every PERIOD low cycles.
  - Go to IDLE with no err. Duty 0 has no rising edge, so this is how duty 0 is reported.
- Stuck high: when hi_run reaches PERIOD:
  - err pulse, locked<=0, go to IDLE.
  - No further err until s has gone low and then risen again. A W-bit PWM is never high for a full period.
- Simultaneous events:
  - Rise and low-timeout cannot coincide, because lo_run resets on s=1.
  - Rise takes priority over any counter saturation in the same cycle.
- vld and err are never high in the same cycle.
- duty holds its value between vld pulses. duty is unchanged on err.

## Timing
- Reset values (on the first edge with rst=1): duty=0, vld=0, err=0, locked=0, state IDLE, all counters 0, synchronizer and s_d cleared. Reset mid-period discards the partial measurement.
- Latency, with SYNC=2:
  - Input first sampled high at edge k: s=1 after edge k+1, rise true in the cycle after edge k+1.
  - duty/vld/err register at edge k+2.
  - In general, a rise-triggered update lands at edge k+SYNC.
- First vld after reset or IDLE: exactly PERIOD clocks after the first detected rise, at the second rise.
- Steady state: one vld every PERIOD clocks.
- Duty 0: first vld PERIOD clocks after s went (or stayed) low, then every PERIOD clocks.
- All outputs are registered. No combinational path from PWM_sig to any output.

## Test plan
- Set PWM11 duty=0x400 and hold rst for 2 clocks, driving PWM11's rst_n as ~rst. Required response:
  - First vld 2048 clocks after the first rise, with duty=0x400 and locked=1.
  - vld every 2048 clocks after that; err never asserted.
- PWM11 duty=0x7FF, then duty=0x001. Required response:
  - 0x7FF: duty=0x7FF per period, no err.
  - 0x001: duty=0x001 per period (1-cycle pulse), no err.
- PWM11 duty=0x000. Required response:
  - vld with duty=0x000 every 2048 clocks; locked=1; err=0.
- Bench drives a 50% waveform with a 1000-clock period. Required response:
  - err pulses on every rise after the first; vld never asserted; locked=0.
- Bench holds PWM_sig high for 3000 clocks. Required response:
  - Exactly one err, 2048 clocks after s goes high; state IDLE.
  - After a drop and then a proper duty=0x200 waveform, duty=0x200 is reported one period after the second rise.
- Assert rst for 1 clock midway through a duty=0x300 period. Required response:
  - All outputs 0 at the next edge.
  - No vld until 2048 clocks after the first post-reset rise; then duty=0x300.

Source files
------------

// File: rtl/pwm11_meas.sv
// pwm11_meas: recovers the W-bit duty of a PWM stream with a fixed 2^W-clock
// period, one result per period, and flags wrong-period or stuck-high input.
// Ports:
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   PWM_sig - PWM waveform under measurement (SYNC flops deep synchronizer)
//   duty    - last recovered duty, held between vld pulses
//   vld     - one-cycle pulse, duty just updated
//   err     - one-cycle pulse, period or stuck-high violation
//   locked  - set by a good measurement, cleared by err or rst
module pwm11_meas #(
   parameter int W    = 11,
   parameter int SYNC = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         PWM_sig,
   output logic [W-1:0] duty,
   output logic         vld,
   output logic         err,
   output logic         locked
);

   localparam logic [W:0] PER    = {1'b1, {W{1'b0}}};
   localparam logic [W:0] PER_M1 = {1'b0, {W{1'b1}}};
   localparam logic [W:0] ONE    = {{W{1'b0}}, 1'b1};

   typedef enum logic {
      IDLE,
      MEAS
   } state_t;

   state_t         state_q, state_d;
   logic           s;
   logic           s_d_q;
   logic [W:0]     per_cnt_q, per_cnt_d;
   logic [W:0]     hi_cnt_q, hi_cnt_d;
   logic [W:0]     lo_run_q, lo_run_d;
   logic [W:0]     hi_run_q, hi_run_d;
   logic [W-1:0]   duty_q, duty_d;
   logic           vld_q, vld_d;
   logic           err_q, err_d;
   logic           locked_q, locked_d;
   logic           rise;
   logic           lo_hit;
   logic           hi_hit;

   generate
      if (SYNC == 0) begin : g_nosync
         assign s = PWM_sig;
      end else begin : g_sync
         logic [SYNC-1:0] sync_q;
         always_ff @(posedge clk) begin
            if (rst) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= PWM_sig;
               for (int i = 1; i < SYNC; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end
         assign s = sync_q[SYNC-1];
      end
   endgenerate

   function automatic logic [W:0] sat_inc(input logic [W:0] v);
      return (v == PER) ? PER : v + ONE;
   endfunction

   assign rise = s & ~s_d_q;
   // Runs are counted so that the hit fires in the cycle the run
   // length becomes PERIOD; the low reload to 0 then repeats every
   // PERIOD low cycles.
   assign lo_hit = ~s & (lo_run_q == PER_M1);
   assign hi_hit = s & (hi_run_q == PER_M1);

   always_comb begin
      state_d   = state_q;
      per_cnt_d = per_cnt_q;
      hi_cnt_d  = hi_cnt_q;
      lo_run_d  = lo_run_q;
      hi_run_d  = hi_run_q;
      duty_d    = duty_q;
      vld_d     = 1'b0;
      err_d     = 1'b0;
      locked_d  = locked_q;

      if (s) begin
         lo_run_d = '0;
         hi_run_d = sat_inc(hi_run_q);
      end else begin
         hi_run_d = '0;
         lo_run_d = sat_inc(lo_run_q);
      end

      if (state_q == MEAS) begin
         per_cnt_d = sat_inc(per_cnt_q);
         if (s) begin
            hi_cnt_d = sat_inc(hi_cnt_q);
         end
      end

      // rise needs s=1 and s_d=0, so it excludes both run hits
      unique case (1'b1)
         rise: begin
            per_cnt_d = ONE;
            hi_cnt_d  = ONE;
            state_d   = MEAS;
            if (state_q == MEAS) begin
               if (per_cnt_q == PER) begin
                  duty_d   = hi_cnt_q[W-1:0];
                  vld_d    = 1'b1;
                  locked_d = 1'b1;
               end else begin
                  err_d    = 1'b1;
                  locked_d = 1'b0;
               end
            end
         end
         lo_hit: begin
            duty_d   = '0;
            vld_d    = 1'b1;
            locked_d = 1'b1;
            lo_run_d = '0;
            state_d  = IDLE;
         end
         hi_hit: begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = IDLE;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         s_d_q     <= 1'b0;
         per_cnt_q <= '0;
         hi_cnt_q  <= '0;
         lo_run_q  <= '0;
         hi_run_q  <= '0;
         duty_q    <= '0;
         vld_q     <= 1'b0;
         err_q     <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_d_q     <= s;
         per_cnt_q <= per_cnt_d;
         hi_cnt_q  <= hi_cnt_d;
         lo_run_q  <= lo_run_d;
         hi_run_q  <= hi_run_d;
         duty_q    <= duty_d;
         vld_q     <= vld_d;
         err_q     <= err_d;
         locked_q  <= locked_d;
      end
   end

   assign duty   = duty_q;
   assign vld    = vld_q;
   assign err    = err_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_pwm11_meas.sv
// tb_pwm11_meas: drives PWM patterns into pwm11_meas and checks every
// cycle against a timestamp/queue model of the measurement rules.
module tb_pwm11_meas;
   localparam int W    = 11;
   localparam int SYNC = 2;
   localparam int P    = 2048;

   logic         clk     = 1'b0;
   logic         rst     = 1'b1;
   logic         PWM_sig = 1'b0;
   logic [W-1:0] duty;
   logic         vld;
   logic         err;
   logic         locked;

   pwm11_meas #(.W(W), .SYNC(SYNC)) dut (
      .clk    (clk),
      .rst    (rst),
      .PWM_sig(PWM_sig),
      .duty   (duty),
      .vld    (vld),
      .err    (err),
      .locked (locked)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ncmp  = 0;
   int nfail = 0;
   int ph    = 0;

   // Reference model: s is the input seen SYNC edges ago; rises close a
   // candidate period whose length and high count come from a queue of
   // samples; run lengths come from the start time of the current level.
   bit           pin_h[$] = '{1'b0, 1'b0};
   bit           mq[$];
   bit           ms_prev  = 1'b0;
   bit           m_meas   = 1'b0;
   int           m_t      = 0;
   int           m_tstart = 1;
   logic [W-1:0] m_duty   = '0;
   logic         m_vld    = 1'b0;
   logic         m_err    = 1'b0;
   logic         m_lock   = 1'b0;

   task automatic model_step();
      bit sv;
      int run, per, sum;
      m_t++;
      if (rst) begin
         pin_h = '{1'b0, 1'b0};
         mq = {};
         ms_prev = 1'b0;
         m_meas = 1'b0;
         m_duty = '0;
         m_vld = 1'b0;
         m_err = 1'b0;
         m_lock = 1'b0;
         m_tstart = m_t + 1;
      end else begin
         sv = pin_h[0];
         pin_h.delete(0);
         pin_h.push_back(PWM_sig);
         m_vld = 1'b0;
         m_err = 1'b0;
         if (sv != ms_prev) m_tstart = m_t;
         run = m_t - m_tstart + 1;
         if (sv && !ms_prev) begin
            if (m_meas) begin
               per = (mq.size() > P) ? P : mq.size();
               sum = 0;
               foreach (mq[i]) sum += int'(mq[i]);
               if (per == P) begin
                  m_vld = 1'b1;
                  m_duty = (sum >= P) ? '0 : W'(sum);
                  m_lock = 1'b1;
               end else begin
                  m_err = 1'b1;
                  m_lock = 1'b0;
               end
            end
            m_meas = 1'b1;
            mq = {};
         end else if (!sv && (run % P) == 0) begin
            m_vld = 1'b1;
            m_duty = '0;
            m_lock = 1'b1;
            m_meas = 1'b0;
         end else if (sv && run == P) begin
            m_err = 1'b1;
            m_lock = 1'b0;
            m_meas = 1'b0;
         end
         if (m_meas) mq.push_back(sv);
         ms_prev = sv;
      end
   endtask

   always @(posedge clk) model_step();

   logic [13:0] got_v;
   logic [13:0] exp_v;
   assign got_v = {vld, err, locked, duty};
   assign exp_v = {m_vld, m_err, m_lock, m_duty};

   task automatic step_wave(input int per, input int hi);
      PWM_sig = (ph < hi);
      ph = (ph + 1) % per;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      PWM_sig = 1'b0;
      repeat (2) @(negedge clk);
      ncmp++;
      if (got_v !== 14'd0) begin
         nfail++;
         $display("FAIL reset_out cyc=%0d got=%h want=0", cyc, got_v);
      end
      ncmp++;
      if (got_v !== exp_v) begin
         nfail++;
         $display("FAIL reset_model cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
      end
      rst = 1'b0;
      ph = 0;
   endtask

   task automatic test_duty_400();
      int k, first, prev, nv, ne;
      k = -1; first = -1; prev = -1; nv = 0; ne = 0;
      ph = 0;
      for (int i = 0; i < 4*P; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL duty400 cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (vld) begin
            ncmp++;
            if (first < 0) begin
               first = cyc;
               if (cyc !== k + 2050 || duty !== 11'h400 || locked !== 1'b1) begin
                  nfail++;
                  $display("FAIL duty400_first cyc=%0d duty=%h lk=%b want cyc=%0d duty=400 lk=1",
                           cyc, duty, locked, k + 2050);
               end
            end else if (cyc - prev !== P) begin
               nfail++;
               $display("FAIL duty400_interval got=%0d want=%0d", cyc - prev, P);
            end
            prev = cyc;
            nv++;
         end
         if (err) ne++;
         if (k < 0) k = cyc + 1;
         step_wave(P, 'h400);
      end
      ncmp++;
      if (ne !== 0 || nv !== 3) begin
         nfail++;
         $display("FAIL duty400_counts vld=%0d err=%0d want vld=3 err=0", nv, ne);
      end
   endtask

   task automatic test_extremes();
      logic [W-1:0] la, lb;
      int ne;
      la = '0; lb = '0; ne = 0;
      for (int i = 0; i < 4*P; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL extremes cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (vld) begin
            if (i <= 2*P + 3) la = duty;
            else lb = duty;
         end
         if (err) ne++;
         step_wave(P, (i < 2*P) ? 'h7FF : 'h001);
      end
      ncmp++;
      if (la !== 11'h7FF) begin
         nfail++;
         $display("FAIL duty7ff got=%h want=7ff", la);
      end
      ncmp++;
      if (lb !== 11'h001) begin
         nfail++;
         $display("FAIL duty001 got=%h want=001", lb);
      end
      ncmp++;
      if (ne !== 0) begin
         nfail++;
         $display("FAIL extremes_err got=%0d want=0", ne);
      end
   endtask

   task automatic test_zero();
      int nv, ne;
      nv = 0; ne = 0;
      for (int i = 0; i < 3*P; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL zero cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (vld) begin
            nv++;
            ncmp++;
            if (duty !== '0) begin
               nfail++;
               $display("FAIL zero_duty got=%h want=000", duty);
            end
         end
         if (err) ne++;
         PWM_sig = 1'b0;
      end
      ncmp++;
      if (nv !== 3 || ne !== 0 || locked !== 1'b1) begin
         nfail++;
         $display("FAIL zero_counts vld=%0d err=%0d lk=%b want 3 0 1", nv, ne, locked);
      end
   endtask

   task automatic test_bad_period();
      int nv, ne;
      nv = 0; ne = 0;
      ph = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL badper cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (vld && i >= 8) nv++;
         if (err) ne++;
         step_wave(1000, 500);
      end
      ncmp++;
      if (nv !== 0 || ne !== 4 || locked !== 1'b0) begin
         nfail++;
         $display("FAIL badper_counts vld=%0d err=%0d lk=%b want 0 4 0", nv, ne, locked);
      end
   endtask

   task automatic test_stuck();
      int k, k2, ne, ecyc, vfirst;
      logic [W-1:0] vduty;
      k = 0; k2 = 0; ne = 0; ecyc = -1; vfirst = -1; vduty = '0;
      for (int i = 0; i < 5200 + 3*P; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL stuck cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (i >= 2100 && err) begin
            ne++;
            ecyc = cyc;
         end
         if (i >= 5100 && vld && vfirst < 0) begin
            vfirst = cyc;
            vduty = duty;
         end
         if (i < 2100) begin
            PWM_sig = 1'b0;
         end else if (i < 5100) begin
            if (i == 2100) k = cyc + 1;
            PWM_sig = 1'b1;
         end else if (i < 5200) begin
            PWM_sig = 1'b0;
            ph = 0;
         end else begin
            if (i == 5200) k2 = cyc + 1;
            step_wave(P, 'h200);
         end
      end
      ncmp++;
      if (ne !== 1 || ecyc !== k + 2049) begin
         nfail++;
         $display("FAIL stuck_err n=%0d at=%0d want n=1 at=%0d", ne, ecyc, k + 2049);
      end
      ncmp++;
      if (vfirst !== k2 + 2050 || vduty !== 11'h200) begin
         nfail++;
         $display("FAIL stuck_recover at=%0d duty=%h want at=%0d duty=200",
                  vfirst, vduty, k2 + 2050);
      end
   endtask

   task automatic test_reset_mid();
      int k3, early, vat;
      logic [W-1:0] vduty;
      k3 = -1; early = 0; vat = -1; vduty = '0;
      ph = 0;
      for (int i = 0; i < 4*P; i++) begin
         @(negedge clk);
         ncmp++;
         if (got_v !== exp_v) begin
            nfail++;
            $display("FAIL rstmid cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
         end
         if (i == 3049) begin
            ncmp++;
            if (got_v !== 14'd0) begin
               nfail++;
               $display("FAIL rstmid_out got=%h want=0", got_v);
            end
         end
         if (i > 3049 && vld) begin
            if (k3 >= 0 && cyc == k3 + 2050 && vat < 0) begin
               vat = cyc;
               vduty = duty;
            end else if (vat < 0) begin
               early++;
            end
         end
         rst = (i == 3048);
         if (i == 2*P) k3 = cyc + 1;
         step_wave(P, 'h300);
      end
      rst = 1'b0;
      ncmp++;
      if (early !== 0 || vat !== k3 + 2050 || vduty !== 11'h300) begin
         nfail++;
         $display("FAIL rstmid_first early=%0d at=%0d duty=%h want 0 %0d 300",
                  early, vat, vduty, k3 + 2050);
      end
   endtask

   task automatic test_random();
      int per, hi;
      for (int p = 0; p < 8; p++) begin
         per = (p < 4) ? P : int'($urandom_range(2600, 1500));
         hi  = (p < 4) ? int'($urandom_range(P - 1, 0))
                       : int'($urandom_range(per - 1, 1));
         for (int j = 0; j < per; j++) begin
            @(negedge clk);
            ncmp++;
            if (got_v !== exp_v) begin
               nfail++;
               $display("FAIL random cyc=%0d got=%h want=%h", cyc, got_v, exp_v);
            end
            ncmp++;
            if (vld && err) begin
               nfail++;
               $display("FAIL vld_err_excl cyc=%0d got=11 want=not both", cyc);
            end
            PWM_sig = (j < hi);
         end
      end
   endtask

   initial begin
      test_reset();
      test_duty_400();
      test_extremes();
      test_zero();
      test_bad_period();
      test_stuck();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
